// File: rtl/mux_out_accumulator_pkg.sv
// Shared types and defaults for the mux result accumulator.
// SEL_W must track the select width of the upstream operation mux.
package mux_out_accumulator_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 12;
  localparam int DEF_CNT_W  = 5;
  localparam int SEL_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mux_out_accumulator.sv
// Sums a programmed number of mux results under valid/ready, then pulses done.
// Overflow is a sticky carry out of the accumulator, cleared by the next start.
module mux_out_accumulator
  import mux_out_accumulator_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [SEL_W-1:0]  last_sel
);

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  remaining;
  logic [ACC_W:0]    sum;
  logic              accept;
  logic              start_ok;

  // Unsigned wrap-around add; the MSB of the result is the carry out.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                              input logic [DATA_W-1:0] d);
    acc_add = {1'b0, a} + {{(ACC_W + 1 - DATA_W){1'b0}}, d};
  endfunction

  assign sum      = acc_add(acc, in_data);
  assign accept   = in_valid && in_ready;
  assign start_ok = (state == IDLE) && start;
  assign acc_out  = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (count != '0) ? ACCUM : DONE;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && (remaining == CNT_W'(1))) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      overflow  <= 1'b0;
      remaining <= '0;
      last_sel  <= '0;
    end else if (start_ok) begin
      acc       <= '0;
      overflow  <= 1'b0;
      remaining <= count;
    end else if (accept) begin
      acc       <= sum[ACC_W-1:0];
      overflow  <= overflow | sum[ACC_W];
      remaining <= remaining - CNT_W'(1);
      last_sel  <= in_sel;
    end
  end

endmodule

// File: tb/tb_mux_out_accumulator.sv
// Directed bench for mux_out_accumulator with hand-computed expectations.
module tb_mux_out_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_ready;
  logic [11:0] acc_out;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [2:0]  last_sel;

  int tests = 0;
  int fails = 0;

  mux_out_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel),
    .in_ready(in_ready), .acc_out(acc_out), .busy(busy), .done(done),
    .overflow(overflow), .last_sel(last_sel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0; in_data = '0; in_sel = '0;
    step(); step();
    tests++;
    if ({acc_out, busy, done, overflow, in_ready, last_sel} !== 19'd0) begin
      fails++;
      $display("FAIL reset_outputs: got acc=%0d busy=%b done=%b ovf=%b rdy=%b sel=%0d want all 0",
               acc_out, busy, done, overflow, in_ready, last_sel);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    start = 1'b1; count = 5'd3;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd1; in_sel = 3'd4;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL basic_ready: got rdy=%b busy=%b want 1 1", in_ready, busy);
    end
    step(); in_data = 8'd3;
    step(); in_data = 8'd5;
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL basic_early_done: got %b want 0", done);
    end
    step(); in_valid = 1'b0;
    tests++;
    if (done !== 1'b1 || acc_out !== 12'd9 || overflow !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: got done=%b acc=%0d ovf=%b rdy=%b want 1 9 0 0",
               done, acc_out, overflow, in_ready);
    end
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || acc_out !== 12'd9 || last_sel !== 3'd4) begin
      fails++;
      $display("FAIL basic_idle: got done=%b busy=%b acc=%0d sel=%0d want 0 0 9 4",
               done, busy, acc_out, last_sel);
    end
  endtask

  task automatic test_gaps();
    start = 1'b1; count = 5'd2;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd3; in_sel = 3'd1;
    step();
    in_valid = 1'b0; in_data = 8'd99; in_sel = 3'd7;
    tests++;
    if (acc_out !== 12'd3 || last_sel !== 3'd1) begin
      fails++; $display("FAIL gaps_first: got acc=%0d sel=%0d want 3 1", acc_out, last_sel);
    end
    step(); step(); step();
    tests++;
    if (acc_out !== 12'd3 || busy !== 1'b1 || done !== 1'b0 || last_sel !== 3'd1) begin
      fails++;
      $display("FAIL gaps_hold: got acc=%0d busy=%b done=%b sel=%0d want 3 1 0 1",
               acc_out, busy, done, last_sel);
    end
    in_valid = 1'b1; in_data = 8'd5; in_sel = 3'd2;
    step();
    in_valid = 1'b0;
    tests++;
    if (done !== 1'b1 || acc_out !== 12'd8 || last_sel !== 3'd2) begin
      fails++;
      $display("FAIL gaps_done: got done=%b acc=%0d sel=%0d want 1 8 2", done, acc_out, last_sel);
    end
    step();
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL gaps_pulse_len: got done=%b want 0", done);
    end
  endtask

  task automatic test_overflow();
    start = 1'b1; count = 5'd17;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd255; in_sel = 3'd3;
    for (int i = 0; i < 16; i++) step();
    tests++;
    if (acc_out !== 12'd4080 || overflow !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL ovf_pre: got acc=%0d ovf=%b done=%b want 4080 0 0", acc_out, overflow, done);
    end
    step();
    in_valid = 1'b0;
    tests++;
    if (done !== 1'b1 || acc_out !== 12'd239 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_wrap: got done=%b acc=%0d ovf=%b want 1 239 1", done, acc_out, overflow);
    end
    step(); step(); step();
    tests++;
    if (busy !== 1'b0 || overflow !== 1'b1 || acc_out !== 12'd239) begin
      fails++;
      $display("FAIL ovf_sticky: got busy=%b ovf=%b acc=%0d want 0 1 239", busy, overflow, acc_out);
    end
    start = 1'b1; count = 5'd1;
    step();
    start = 1'b0;
    tests++;
    if (overflow !== 1'b0 || acc_out !== 12'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL ovf_clear: got ovf=%b acc=%0d busy=%b want 0 0 1", overflow, acc_out, busy);
    end
    in_valid = 1'b1; in_data = 8'd4; in_sel = 3'd5;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_zero_count();
    tests++;
    if (acc_out !== 12'd4) begin
      fails++; $display("FAIL zero_setup: got acc=%0d want 4", acc_out);
    end
    start = 1'b1; count = 5'd0; in_valid = 1'b1; in_data = 8'd50; in_sel = 3'd6;
    step();
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || acc_out !== 12'd0 || in_ready !== 1'b0 || last_sel !== 3'd5) begin
      fails++;
      $display("FAIL zero_done: got done=%b acc=%0d rdy=%b sel=%0d want 1 0 0 5",
               done, acc_out, in_ready, last_sel);
    end
    step();
    in_valid = 1'b0;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || acc_out !== 12'd0) begin
      fails++;
      $display("FAIL zero_idle: got done=%b busy=%b rdy=%b acc=%0d want 0 0 0 0",
               done, busy, in_ready, acc_out);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] vals [4];
    vals[0] = 8'd10; vals[1] = 8'd20; vals[2] = 8'd30; vals[3] = 8'd40;
    start = 1'b1; count = 5'd4;
    step();
    count = 5'd9; in_valid = 1'b1; in_sel = 3'd2;
    for (int i = 0; i < 4; i++) begin
      in_data = vals[i];
      step();
    end
    start = 1'b0; in_valid = 1'b0;
    tests++;
    if (done !== 1'b1 || acc_out !== 12'd100) begin
      fails++; $display("FAIL midstart_done: got done=%b acc=%0d want 1 100", done, acc_out);
    end
    step();
    tests++;
    if (busy !== 1'b0 || acc_out !== 12'd100) begin
      fails++; $display("FAIL midstart_idle: got busy=%b acc=%0d want 0 100", busy, acc_out);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; count = 5'd5;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd2; in_sel = 3'd6;
    step();
    in_data = 8'd3;
    step();
    tests++;
    if (acc_out !== 12'd5 || busy !== 1'b1) begin
      fails++; $display("FAIL arst_pre: got acc=%0d busy=%b want 5 1", acc_out, busy);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({acc_out, busy, done, overflow, in_ready, last_sel} !== 19'd0) begin
      fails++;
      $display("FAIL arst_now: got acc=%0d busy=%b done=%b ovf=%b rdy=%b sel=%0d want all 0",
               acc_out, busy, done, overflow, in_ready, last_sel);
    end
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL arst_no_done: got done=%b busy=%b want 0 0", done, busy);
      end
    end
    start = 1'b1; count = 5'd1;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'd7; in_sel = 3'd1;
    step();
    in_valid = 1'b0;
    tests++;
    if (done !== 1'b1 || acc_out !== 12'd7 || last_sel !== 3'd1) begin
      fails++;
      $display("FAIL arst_rerun: got done=%b acc=%0d sel=%0d want 1 7 1", done, acc_out, last_sel);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_zero_count();
    test_start_ignored();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_out_accumulator.md
Name: mux_out_accumulator

Overview:
- Downstream consumer of the 8-bit operation mux (operands X/Y, 3-bit sel, 8-bit out).
- Accumulates a programmed number of mux results into a wider register under a valid/ready handshake.
- Reports completion with a one-cycle done pulse and a sticky overflow flag.
- Feeds the datapath result/writeback stage.

Parameters:
- DATA_W, 8: width of the incoming mux result.
- ACC_W, 12: accumulator width; must be greater than DATA_W.
- CNT_W, 5: width of the sample-count field; up to 2^CNT_W-1 samples per run.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin a run; honoured only in IDLE.
- count  in  CNT_W  number of samples for this run; sampled only on an honoured start.
- in_valid  in  1  mux result valid.
- in_data  in  DATA_W  mux result (mux out).
- in_sel  in  3  sel value that produced in_data.
- in_ready  out  1  block accepts a sample this cycle.
- acc_out  out  ACC_W  accumulator value.
- busy  out  1  high in ACCUM and DONE.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky carry out of ACC_W during the current or last run.
- last_sel  out  3  in_sel of the most recently accepted sample.

Behaviour:
- Reset (async, any state, mid-run included): state=IDLE; acc_out=0; remaining=0; in_ready=0; busy=0; done=0; overflow=0; last_sel=0. An in-flight run is abandoned with no done pulse.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 with count!=0: acc<=0, overflow<=0, remaining<=count, go to ACCUM.
  - start=1 with count==0: acc<=0, overflow<=0, go directly to DONE.
- ACCUM:
  - in_ready=1 combinationally, busy=1.
  - Accept when in_valid && in_ready. On accept:
    - acc <= (acc + zero-extended in_data) mod 2^ACC_W.
    - overflow is set if the addition carries out of ACC_W; it stays set.
    - last_sel <= in_sel.
    - remaining <= remaining-1.
  - Accept with remaining==1: go to DONE. Otherwise stay in ACCUM.
  - in_valid=0: no change; gaps of any length are allowed.
- DONE:
  - done=1, busy=1, in_ready=0. Lasts exactly one cycle, then IDLE.
  - acc_out is final during the done cycle.
- Latency: done asserts the cycle after the last accepted sample. A zero-count run asserts done the cycle after start.
- start is ignored in ACCUM and DONE; it is not queued.
- After returning to IDLE, acc_out, overflow and last_sel hold until the next honoured start.
- in_data and in_sel are sampled only on an accept. Values presented while in_ready=0 are dropped.
- Arithmetic is unsigned only; no saturation, wrap only.

Decomposition:
- Shared package:
  - state enum (IDLE, ACCUM, DONE).
  - DATA_W / ACC_W / CNT_W defaults.
  - SEL_W=3 constant, shared with the mux.
- Single module. No sub-module is natural; the counter and adder are a few lines each.

Test Plan:
- count=3, start at T0, then in_data 1,3,5 with in_valid continuous from T1 -> accepts at T1–T3; done=1 at T4 only; acc_out=9; overflow=0; busy low at T5.
- count=2, in_data 3 (sel=1), then in_valid low 3 cycles, then 5 (sel=2) -> acc_out=8; last_sel=2; done one cycle after the second accept.
- count=17, in_data=255 every cycle -> acc_out=4335 mod 4096=239; overflow=1; overflow stays 1 in IDLE and clears on the next start.
- count=0 start at T0 -> done=1 at T1; acc_out=0; in_ready never high.
- Mid-run start=1 with a new count=9 during ACCUM with count=4 -> ignored; run completes after 4 accepts; acc equals the sum of those 4.
- rst pulsed asynchronously between edges after 2 of 5 accepts -> outputs zero immediately; no done pulse; a subsequent start with count=1 and data 7 gives acc_out=7.
